// File: rtl/fpr_cdb_arbiter_pkg.sv
// Shared definitions for the FPR common data bus: ROB tag width, the broadcast
// bus type and the tag-match helper used by bus consumers.
package fpr_cdb_arbiter_pkg;

    localparam int ROB_WIDTH = 6;

    typedef struct packed {
        logic                 valid;
        logic [ROB_WIDTH-1:0] tag;
        logic [31:0]          data;
    } cdb_t;

    // A consumer only reacts to a broadcast that is valid and carries its tag.
    function automatic logic tag_match(input cdb_t cdb, input logic [ROB_WIDTH-1:0] tag);
        return cdb.valid && (cdb.tag == tag);
    endfunction

    // Width of an index into N requesters; a single requester still gets one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fpr_cdb_arbiter_if.sv
// Request/grant handshake and broadcast bundle between the FP execution units
// and the FPR CDB arbiter. master = unit/consumer side, slave = arbiter side.
interface fpr_cdb_arbiter_if
    import fpr_cdb_arbiter_pkg::*;
#(
    parameter int N_REQ = 4
);

    logic [N_REQ-1:0]                req_valid;
    logic [N_REQ-1:0]                req_ready;
    logic [N_REQ-1:0][ROB_WIDTH-1:0] req_tag;
    logic [N_REQ-1:0][31:0]          req_data;
    cdb_t                            fpr_cdb;
    logic [N_REQ-1:0][31:0]          grant_cnt;

    modport master (
        output req_valid, req_tag, req_data,
        input  req_ready, fpr_cdb, grant_cnt
    );

    modport slave (
        input  req_valid, req_tag, req_data,
        output req_ready, fpr_cdb, grant_cnt
    );

endinterface

// File: rtl/fpr_cdb_arbiter_cdb_pick.sv
// Combinational picker: scans the request vector starting at base_i and
// wrapping modulo N_REQ, returning the first requester as one-hot and index.
module cdb_pick
    import fpr_cdb_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    localparam int IDX_W = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] base_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    // First set request at or after base_i (circularly) wins.
    always_comb begin
        logic [IDX_W-1:0] cand;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        cand  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = IDX_W'((int'(base_i) + k) % N_REQ);
            if (!any_o && req_i[cand]) begin
                any_o       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

endmodule

// File: rtl/fpr_cdb_arbiter.sv
// FPR common data bus arbiter: grants one FP unit per cycle, registers the
// winner's index and tag, and broadcasts {valid, tag, data} one cycle later
// with data muxed from the winner's result register.
// Build option: define FPR_CDB_RR_EN for round-robin arbitration; otherwise
// index 0 has fixed highest priority.
module fpr_cdb_arbiter
    import fpr_cdb_arbiter_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic              clk,
    input  logic              reset,
    fpr_cdb_arbiter_if.slave  bus
);

    localparam int IDX_W = idx_width(N_REQ);

    logic [N_REQ-1:0]       pick_gnt;
    logic [IDX_W-1:0]       pick_idx;
    logic [IDX_W-1:0]       pick_base;
    logic                   pick_any;
    logic                   xfer;

    logic                   gnt_v_q,     gnt_v_d;
    logic [IDX_W-1:0]       gnt_idx_q,   gnt_idx_d;
    logic [ROB_WIDTH-1:0]   gnt_tag_q,   gnt_tag_d;
    logic [N_REQ-1:0][31:0] grant_cnt_q, grant_cnt_d;

`ifdef FPR_CDB_RR_EN
    logic [IDX_W-1:0]       rr_ptr_q,    rr_ptr_d;

    assign pick_base = rr_ptr_q;

    // After a transfer the unit just past the winner becomes highest priority.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (xfer) begin
            rr_ptr_d = (pick_idx == IDX_W'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`else
    assign pick_base = '0;
`endif

    cdb_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req_i  (bus.req_valid),
        .base_i (pick_base),
        .gnt_o  (pick_gnt),
        .idx_o  (pick_idx),
        .any_o  (pick_any)
    );

    // Reset suppresses every grant so no unit believes it was accepted.
    assign xfer          = pick_any && !reset;
    assign bus.req_ready = reset ? '0 : pick_gnt;

    // Capture the winner for next cycle's broadcast; tag holds when idle.
    always_comb begin
        gnt_v_d     = xfer;
        gnt_idx_d   = gnt_idx_q;
        gnt_tag_d   = gnt_tag_q;
        grant_cnt_d = grant_cnt_q;
        if (xfer) begin
            gnt_idx_d             = pick_idx;
            gnt_tag_d             = bus.req_tag[pick_idx];
            grant_cnt_d[pick_idx] = grant_cnt_q[pick_idx] + 32'd1;
        end
    end

    // Grant pipeline and performance counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            gnt_v_q     <= 1'b0;
            gnt_idx_q   <= '0;
            gnt_tag_q   <= '0;
            grant_cnt_q <= '0;
        end else begin
            gnt_v_q     <= gnt_v_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_tag_q   <= gnt_tag_d;
            grant_cnt_q <= grant_cnt_d;
        end
    end

    // Data comes straight from the winning unit's result register.
    assign bus.fpr_cdb   = '{valid: gnt_v_q, tag: gnt_tag_q, data: bus.req_data[gnt_idx_q]};
    assign bus.grant_cnt = grant_cnt_q;

endmodule

// File: tb/tb_fpr_cdb_arbiter.sv
// Self-checking bench for fpr_cdb_arbiter: directed scenarios with expected
// values taken from the arbitration rules, then a randomized run against a
// queue-free behavioural model of grant order, broadcast and counters.
module tb_fpr_cdb_arbiter;
    import fpr_cdb_arbiter_pkg::*;

    localparam int N = 4;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    fpr_cdb_arbiter_if #(.N_REQ(N)) bus ();

    fpr_cdb_arbiter #(.N_REQ(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // 10 time-unit clock; inputs change at negedge, outputs sampled 1 unit later.
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus.req_valid = '0;
        bus.req_tag   = '0;
        bus.req_data  = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        tick();
        tick();
        reset = 1'b0;
    endtask

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Reference winner: first requester scanning circularly from the priority
    // index; nothing is granted while reset is high.
    function automatic int model_pick(input logic [N-1:0] v, input int prio, input logic rst);
        if (rst) return -1;
        for (int k = 0; k < N; k++) begin
            if (v[(prio + k) % N]) return (prio + k) % N;
        end
        return -1;
    endfunction

    task automatic test_reset();
        reset         = 1'b1;
        bus.req_valid = '1;
        bus.req_tag   = '1;
        #1;
        checks++;
        if (bus.req_ready !== '0) begin
            failures++;
            $display("[TB] FAIL reset_ready: got %b, expected 0000", bus.req_ready);
        end
        tick();
        #1;
        checks++;
        if (bus.req_ready !== '0) begin
            failures++;
            $display("[TB] FAIL reset_ready2: got %b, expected 0000", bus.req_ready);
        end
        checks++;
        if (bus.fpr_cdb.valid !== 1'b0 || bus.fpr_cdb.tag !== '0) begin
            failures++;
            $display("[TB] FAIL reset_cdb: got v=%b tag=%0d, expected v=0 tag=0", bus.fpr_cdb.valid, bus.fpr_cdb.tag);
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (bus.grant_cnt[i] !== 32'd0) begin
                failures++;
                $display("[TB] FAIL reset_cnt%0d: got %0d, expected 0", i, bus.grant_cnt[i]);
            end
        end
        reset = 1'b0;
        clear_inputs();
        tick();
    endtask

    task automatic test_single();
        do_reset();
        bus.req_valid  = 4'b0100;
        bus.req_tag[2] = ROB_WIDTH'(5);
        #1;
        checks++;
        if (bus.req_ready !== 4'b0100) begin
            failures++;
            $display("[TB] FAIL single_ready: got %b, expected 0100", bus.req_ready);
        end
        tick();
        bus.req_valid   = '0;
        bus.req_data[2] = 32'h3F80_0000;
        #1;
        checks++;
        if (bus.fpr_cdb !== {1'b1, ROB_WIDTH'(5), 32'h3F80_0000}) begin
            failures++;
            $display("[TB] FAIL single_cdb: got %h, expected v=1 tag=5 data=3f800000", bus.fpr_cdb);
        end
        checks++;
        if (bus.grant_cnt[2] !== 32'd1 || bus.grant_cnt[0] !== 32'd0) begin
            failures++;
            $display("[TB] FAIL single_cnt: got cnt2=%0d cnt0=%0d, expected 1 and 0", bus.grant_cnt[2], bus.grant_cnt[0]);
        end
        tick();
        #1;
        checks++;
        if (bus.fpr_cdb.valid !== 1'b0 || bus.fpr_cdb.tag !== ROB_WIDTH'(5)) begin
            failures++;
            $display("[TB] FAIL single_hold: got v=%b tag=%0d, expected v=0 tag=5", bus.fpr_cdb.valid, bus.fpr_cdb.tag);
        end
    endtask

    task automatic test_contention();
        int order[3] = '{0, 1, 3};
        do_reset();
        bus.req_valid = 4'b1011;
        for (int i = 0; i < N; i++) bus.req_tag[i] = ROB_WIDTH'(10 + i);
        for (int k = 0; k <= 3; k++) begin
            #1;
            if (k > 0) begin
                checks++;
                if (bus.fpr_cdb !== {1'b1, ROB_WIDTH'(10 + order[k-1]), 32'hC0DE_0000 + 32'(order[k-1])}) begin
                    failures++;
                    $display("[TB] FAIL contention_cdb%0d: got %h, expected unit %0d", k, bus.fpr_cdb, order[k-1]);
                end
            end
            checks++;
            if (bus.req_ready !== ((k < 3) ? onehot(order[k]) : 4'b0000)) begin
                failures++;
                $display("[TB] FAIL contention_ready%0d: got %b, expected %b", k, bus.req_ready, (k < 3) ? onehot(order[k]) : 4'b0000);
            end
            tick();
            if (k < 3) begin
                bus.req_valid[order[k]] = 1'b0;
                bus.req_data[order[k]]  = 32'hC0DE_0000 + 32'(order[k]);
            end
        end
    endtask

    task automatic test_all_valid();
        int exp_idx;
        int prev;
        prev = 0;
        do_reset();
        bus.req_valid = '1;
        for (int i = 0; i < N; i++) bus.req_tag[i] = ROB_WIDTH'(20 + i);
        for (int k = 0; k < 8; k++) begin
`ifdef FPR_CDB_RR_EN
            exp_idx = k % N;
`else
            exp_idx = 0;
`endif
            #1;
            checks++;
            if (bus.req_ready !== onehot(exp_idx)) begin
                failures++;
                $display("[TB] FAIL allvalid_ready%0d: got %b, expected %b", k, bus.req_ready, onehot(exp_idx));
            end
            if (k > 0) begin
                checks++;
                if (bus.fpr_cdb.valid !== 1'b1 || bus.fpr_cdb.tag !== ROB_WIDTH'(20 + prev)) begin
                    failures++;
                    $display("[TB] FAIL allvalid_tag%0d: got v=%b tag=%0d, expected v=1 tag=%0d", k, bus.fpr_cdb.valid, bus.fpr_cdb.tag, 20 + prev);
                end
            end
            prev = exp_idx;
            tick();
        end
        bus.req_valid = '0;
        #1;
        for (int i = 0; i < N; i++) begin
            checks++;
`ifdef FPR_CDB_RR_EN
            if (bus.grant_cnt[i] !== 32'd2) begin
                failures++;
                $display("[TB] FAIL allvalid_cnt%0d: got %0d, expected 2", i, bus.grant_cnt[i]);
            end
`else
            if (bus.grant_cnt[i] !== ((i == 0) ? 32'd8 : 32'd0)) begin
                failures++;
                $display("[TB] FAIL allvalid_cnt%0d: got %0d, expected %0d", i, bus.grant_cnt[i], (i == 0) ? 8 : 0);
            end
`endif
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        bus.req_valid = 4'b0010;
        for (int k = 0; k <= 3; k++) begin
            if (k < 3) bus.req_tag[1] = ROB_WIDTH'(7 + k);
            #1;
            if (k > 0) begin
                checks++;
                if (bus.fpr_cdb !== {1'b1, ROB_WIDTH'(6 + k), 32'h100 + 32'(k - 1)}) begin
                    failures++;
                    $display("[TB] FAIL b2b_cdb%0d: got %h, expected tag=%0d data=%0h", k, bus.fpr_cdb, 6 + k, 32'h100 + k - 1);
                end
            end
            checks++;
            if (bus.req_ready !== ((k < 3) ? 4'b0010 : 4'b0000)) begin
                failures++;
                $display("[TB] FAIL b2b_ready%0d: got %b", k, bus.req_ready);
            end
            tick();
            bus.req_data[1] = 32'h100 + 32'(k);
            if (k == 2) bus.req_valid = '0;
        end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        bus.req_valid  = 4'b0001;
        bus.req_tag[0] = ROB_WIDTH'(3);
        #1;
        checks++;
        if (bus.req_ready !== 4'b0001) begin
            failures++;
            $display("[TB] FAIL midrst_grant: got %b, expected 0001", bus.req_ready);
        end
        tick();
        reset           = 1'b1;
        bus.req_valid   = 4'b1111;
        bus.req_data[0] = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (bus.req_ready !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL midrst_ready: got %b, expected 0000", bus.req_ready);
        end
        checks++;
        if (bus.fpr_cdb !== {1'b1, ROB_WIDTH'(3), 32'hDEAD_BEEF}) begin
            failures++;
            $display("[TB] FAIL midrst_cdb: got %h, expected v=1 tag=3 data=deadbeef", bus.fpr_cdb);
        end
        tick();
        reset         = 1'b0;
        bus.req_valid = '0;
        #1;
        checks++;
        if (bus.fpr_cdb.valid !== 1'b0 || bus.grant_cnt !== '0) begin
            failures++;
            $display("[TB] FAIL midrst_after: got v=%b cnt=%h, expected v=0 cnt=0", bus.fpr_cdb.valid, bus.grant_cnt);
        end
    endtask

    task automatic test_idle();
        do_reset();
        bus.req_valid  = 4'b0010;
        bus.req_tag[1] = ROB_WIDTH'(4);
        tick();
        bus.req_valid = '0;
        tick();
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++;
            if (bus.req_ready !== '0 || bus.fpr_cdb.valid !== 1'b0 || bus.grant_cnt[1] !== 32'd1) begin
                failures++;
                $display("[TB] FAIL idle%0d: got ready=%b v=%b cnt1=%0d, expected 0000/0/1", k, bus.req_ready, bus.fpr_cdb.valid, bus.grant_cnt[1]);
            end
            tick();
        end
        bus.req_valid = '1;
        #1;
        checks++;
`ifdef FPR_CDB_RR_EN
        if (bus.req_ready !== 4'b0100) begin
            failures++;
            $display("[TB] FAIL idle_prio: got %b, expected 0100", bus.req_ready);
        end
`else
        if (bus.req_ready !== 4'b0001) begin
            failures++;
            $display("[TB] FAIL idle_prio: got %b, expected 0001", bus.req_ready);
        end
`endif
        tick();
        bus.req_valid = '0;
    endtask

    task automatic test_random();
        logic                 m_valid;
        logic [ROB_WIDTH-1:0] m_tag;
        int                   m_idx;
        int                   m_prio;
        int unsigned          m_cnt[N];
        logic [31:0]          dat[N];
        logic [ROB_WIDTH-1:0] tags[N];
        logic [N-1:0]         v;
        logic [N-1:0]         exp_ready;
        logic                 rst;
        int                   p;
        do_reset();
        m_valid = 1'b0;
        m_tag   = '0;
        m_idx   = 0;
        m_prio  = 0;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            rst = ($urandom_range(0, 39) == 0);
            v   = N'($urandom_range(0, (1 << N) - 1));
            for (int i = 0; i < N; i++) begin
                tags[i] = ROB_WIDTH'($urandom);
                dat[i]  = $urandom;
                bus.req_tag[i]  = tags[i];
                bus.req_data[i] = dat[i];
            end
            reset         = rst;
            bus.req_valid = v;
            #1;
            p         = model_pick(v, m_prio, rst);
            exp_ready = (p >= 0) ? onehot(p) : '0;
            checks++;
            if (bus.req_ready !== exp_ready) begin
                failures++;
                $display("[TB] FAIL rand_ready@%0d: got %b, expected %b", cyc, bus.req_ready, exp_ready);
            end
            checks++;
            if (bus.fpr_cdb.valid !== m_valid || bus.fpr_cdb.tag !== m_tag) begin
                failures++;
                $display("[TB] FAIL rand_cdb@%0d: got v=%b tag=%0d, expected v=%b tag=%0d", cyc, bus.fpr_cdb.valid, bus.fpr_cdb.tag, m_valid, m_tag);
            end
            if (m_valid) begin
                checks++;
                if (bus.fpr_cdb.data !== dat[m_idx]) begin
                    failures++;
                    $display("[TB] FAIL rand_data@%0d: got %h, expected %h", cyc, bus.fpr_cdb.data, dat[m_idx]);
                end
            end
            tick();
            if (rst) begin
                m_valid = 1'b0;
                m_tag   = '0;
                m_idx   = 0;
                m_prio  = 0;
                for (int i = 0; i < N; i++) m_cnt[i] = 0;
            end else if (p >= 0) begin
                m_valid  = 1'b1;
                m_tag    = tags[p];
                m_idx    = p;
                m_cnt[p] = m_cnt[p] + 1;
`ifdef FPR_CDB_RR_EN
                m_prio   = (p + 1) % N;
`endif
            end else begin
                m_valid = 1'b0;
            end
        end
        reset         = 1'b0;
        bus.req_valid = '0;
        #1;
        for (int i = 0; i < N; i++) begin
            checks++;
            if (bus.grant_cnt[i] !== m_cnt[i]) begin
                failures++;
                $display("[TB] FAIL rand_cnt%0d: got %0d, expected %0d", i, bus.grant_cnt[i], m_cnt[i]);
            end
        end
        tick();
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        @(negedge clk);
        test_reset();
        test_single();
        test_contention();
        test_all_valid();
        test_back_to_back();
        test_reset_midstream();
        test_idle();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fpr_cdb_arbiter.md
Name: fpr_cdb_arbiter

Overview:
- Shares the single FPR common data bus (fpr_cdb) between N_REQ floating-point execution units (fmov, fadd, fmul, fdiv, ...).
- Each unit presents valid/tag on the req_if handshake and drives its result from its own register one cycle after the handshake.
- The block grants at most one unit per cycle, pipelines the winning tag, and broadcasts {valid, tag, data} to reservation stations, FPR file and ROB.

Parameters:
- N_REQ, 4, number of requesting FP units; index 0 is highest fixed priority.
- ROB_WIDTH, from common package, ROB tag width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  N_REQ  unit i has a dispatchable result (fpr_cdb_req.valid of unit i).
- req_ready  out  N_REQ  grant to unit i (fpr_cdb_req.ready of unit i); at most one bit set.
- req_tag  in  N_REQ x ROB_WIDTH  ROB tag of unit i's candidate, valid in the request cycle.
- req_data  in  N_REQ x 32  result register of unit i, valid in the cycle after its grant.
- fpr_cdb  out  cdb_t (1+ROB_WIDTH+32)  broadcast bus.
- grant_cnt  out  N_REQ x 32  per-unit accepted-transfer counters (performance).

Behaviour:
- Handshake: transfer for unit i occurs in cycle t when req_valid[i] && req_ready[i]. req_ready is combinational from req_valid in the same cycle. A unit must not depend on ready to raise valid.
- Grant selection (default): lowest index with req_valid set wins. req_ready is one-hot or zero. No request means no grant.
- Pipeline registers: gnt_v, gnt_idx[$clog2(N_REQ)], gnt_tag. At a transfer in cycle t, these load 1/i/req_tag[i]; otherwise gnt_v loads 0.
- Output in cycle t+1:
  - fpr_cdb.valid = gnt_v.
  - fpr_cdb.tag = gnt_tag.
  - fpr_cdb.data = req_data[gnt_idx], a combinational mux; it is don't-care when gnt_v=0.
- Latency: request to broadcast is 1 cycle. Throughput is 1 broadcast per cycle. Back-to-back grants to the same unit are legal.
- Simultaneous requests: losers keep req_valid asserted and are re-arbitrated next cycle. The block holds no request state for losers.
- fpr_cdb.tag when !fpr_cdb.valid: hold the last value; consumers must qualify with valid (tag_match).
- grant_cnt[i] increments by 1 on each transfer of unit i and wraps at 2^32-1 -> 0.
- Reset:
  - While reset=1, req_ready forced all-zero, so no transfer occurs even if valid is high.
  - Next cycle: gnt_v=0, fpr_cdb.valid=0, gnt_idx=0, gnt_tag=0, grant_cnt all 0, rr_ptr=0.
- Reset mid-operation: a grant registered in the cycle before reset still broadcasts in the reset cycle, since the output is a register. The cycle after reset shows fpr_cdb.valid=0.
- Single-requester case (N_REQ=1): req_ready=req_valid, gnt_idx constant 0.

Optional Feature:
- Macro FPR_CDB_RR_EN.
- Defined: round-robin grant. Register rr_ptr (N_REQ-wide index) is the highest-priority index. The search order is rr_ptr, rr_ptr+1, ... modulo N_REQ. On a transfer by unit i, rr_ptr <= (i+1) mod N_REQ. With no transfer, rr_ptr holds. The default wrap from N_REQ-1 is to 0.
- Undefined: fixed priority as above; rr_ptr is not present.
- Latency, one-hot grant and the reset rules are identical in both builds.

Decomposition:
- Shared package (common.vh): ROB_WIDTH, cdb_t {valid, tag[ROB_WIDTH], data[32]}, tag_match(). The existing definitions are reused; nothing new is added.
- Sub-module cdb_pick (N_REQ parameter):
  - Inputs: req vector, base index.
  - Outputs: one-hot grant, encoded index, any.
  - Purely combinational. The fixed-priority build ties base to 0.

Test Plan:
- Single request: req_valid=4'b0100 with tag=5, req_data[2]=0x3F800000 next cycle -> req_ready=4'b0100 at t; fpr_cdb={1,5,0x3F800000} at t+1; grant_cnt[2]=1.
- Contention (fixed priority): req_valid=4'b1011 held 3 cycles, dropping each winner's bit after its grant -> grants in order 0, 1, 3; broadcasts on consecutive cycles; no idle cycle.
- Contention (FPR_CDB_RR_EN): all four valid continuously for 8 cycles -> grant order 0, 1, 2, 3, 0, 1, 2, 3; each grant_cnt=2.
- Back-to-back same unit: unit 1 valid for 3 cycles with tags 7, 8, 9 -> fpr_cdb tags 7, 8, 9 on 3 consecutive cycles, data from req_data[1] each following cycle.
- Reset mid-stream: grant unit 0 (tag 3) at t, reset=1 at t+1 with req_valid=4'b1111 -> fpr_cdb.valid=1 tag 3 at t+1; req_ready=0 at t+1; fpr_cdb.valid=0 at t+2; counters 0.
- Idle: req_valid=0 for 5 cycles -> req_ready=0, fpr_cdb.valid=0, counters and rr_ptr unchanged.
